// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: state and owner encodings, bus widths and
// the fixed-priority pick used in IDLE.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'b00,
    ArbBusy = 2'b01,
    ArbDone = 2'b10
  } arb_state_e;

  typedef enum logic {
    OwnerVga = 1'b0,
    OwnerCpu = 1'b1
  } owner_e;

  localparam int unsigned BusAw = 32;
  localparam int unsigned BusDw = 32;
  localparam int unsigned TmoW  = 4;

  // VGA wins unless the CPU is waiting and VGA has used up its burst allowance.
  function automatic owner_e arb_pick(logic m0_req, logic m1_req, logic streak_full);
    if (m0_req && !(m1_req && streak_full)) begin
      return OwnerVga;
    end
    return OwnerCpu;
  endfunction

endpackage

// File: rtl/arb_timeout.sv
// 4-bit loadable down-counter; expired is high while the count sits at zero.
module arb_timeout
  import mem_bus_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            en,
  input  logic [TmoW-1:0] load_val,
  output logic            expired
);

  logic [TmoW-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single memory port: VGA scanout (m0) has priority, the CPU (m1)
// gets a guaranteed slot after VGA_BURST_MAX contested VGA grants. One access in flight.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned AW            = BusAw,
  parameter int unsigned DW            = BusDw,
  parameter int unsigned VGA_BURST_MAX = 4,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned SW = (VGA_BURST_MAX > 0) ? $clog2(VGA_BURST_MAX + 1) : 1;

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          m0_ack_q, m0_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic          m1_ack_q, m1_ack_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          m1_err_q, m1_err_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          streak_full;
  owner_e        grant;
  logic [DW-1:0] done_data;
  logic          tmo_load, tmo_en, tmo_expired;

  assign streak_full = (streak_q == SW'(VGA_BURST_MAX));

  // Loaded with TIMEOUT-1 so that exactly TIMEOUT BUSY cycles elapse before the abort.
  arb_timeout u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (tmo_load),
    .en       (tmo_en),
    .load_val (TmoW'(TIMEOUT - 1)),
    .expired  (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    m0_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_ack_d    = 1'b0;
    m1_rdata_d  = m1_rdata_q;
    m1_err_d    = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant       = OwnerVga;
    done_data   = '0;
    tmo_load    = 1'b0;
    tmo_en      = 1'b0;

    case (state_q)
      ArbIdle: begin
        if (m0_req || m1_req) begin
          grant     = arb_pick(m0_req, m1_req, streak_full);
          owner_d   = grant;
          state_d   = ArbBusy;
          mem_req_d = 1'b1;
          tmo_load  = 1'b1;
          if (grant == OwnerVga) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = m0_addr;
            mem_wdata_d = '0;
            if (!m1_req) begin
              streak_d = '0;
            end else if (!streak_full) begin
              streak_d = streak_q + 1'b1;
            end
          end else begin
            mem_we_d    = m1_we;
            mem_addr_d  = m1_addr;
            mem_wdata_d = m1_wdata;
            streak_d    = '0;
          end
        end
      end
      ArbBusy: begin
        // Ready takes precedence over a simultaneous timeout.
        if (mem_ready || tmo_expired) begin
          done_data = mem_ready ? mem_rdata : '0;
          state_d   = ArbDone;
          mem_req_d = 1'b0;
          if (owner_q == OwnerVga) begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = done_data;
          end else begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = mem_we_q ? '0 : done_data;
            m1_err_d   = !mem_ready;
          end
        end else begin
          tmo_en = 1'b1;
        end
      end
      ArbDone: begin
        state_d = ArbIdle;
      end
      default: begin
        state_d   = ArbIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ArbIdle;
      owner_q     <= OwnerVga;
      streak_q    <= '0;
      m0_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_ack_q    <= 1'b0;
      m1_rdata_q  <= '0;
      m1_err_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      m0_ack_q    <= m0_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_ack_q    <= m1_ack_d;
      m1_rdata_q  <= m1_rdata_d;
      m1_err_q    <= m1_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_ack    = m1_ack_q;
  assign m1_rdata  = m1_rdata_q;
  assign m1_err    = m1_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single accesses, VGA burst limit, timeout, async reset
// and request drop during an access.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic        m1_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .AW            (32),
    .DW            (32),
    .VGA_BURST_MAX (4),
    .TIMEOUT       (15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({mem_req, mem_we, m0_ack, m1_ack, m1_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, m0_ack, m1_ack, m1_err});
    end
    checks++;
    if ({m0_rdata, m1_rdata, mem_addr, mem_wdata} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", {m0_rdata, m1_rdata, mem_addr, mem_wdata});
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_grant: mem_req got %b expected 0", mem_req);
    end
  endtask

  task automatic test_m1_read;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0010;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0010) begin
      failures++;
      $display("FAIL read_grant: req=%b we=%b addr=%h expected 1 0 00000010", mem_req, mem_we, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_BABE;
    tick();
    checks++;
    if (mem_req !== 1'b0 || m1_ack !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 32'hCAFE_BABE) begin
      failures++;
      $display("FAIL read_ack: req=%b ack=%b err=%b rdata=%h expected 0 1 0 cafebabe",
               mem_req, m1_ack, m1_err, m1_rdata);
    end
    m1_req = 1'b0; mem_ready = 1'b0;
    tick();
    checks++;
    if (m1_ack !== 1'b0) begin
      failures++;
      $display("FAIL read_ack_pulse: ack got %b expected 0", m1_ack);
    end
    tick();
    checks++;
    if (mem_req !== 1'b0 || m1_rdata !== 32'hCAFE_BABE) begin
      failures++;
      $display("FAIL read_hold: req=%b rdata=%h expected 0 cafebabe", mem_req, m1_rdata);
    end
  endtask

  task automatic test_m1_write;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hB000_0004; m1_wdata = 32'h1234_5678;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'hB000_0004 ||
        mem_wdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL write_grant: req=%b we=%b addr=%h wdata=%h expected 1 1 b0000004 12345678",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (m1_ack !== 1'b1 || m1_rdata !== 32'h0 || m1_err !== 1'b0) begin
      failures++;
      $display("FAIL write_ack: ack=%b rdata=%h err=%b expected 1 00000000 0", m1_ack, m1_rdata, m1_err);
    end
    m1_req = 1'b0; m1_we = 1'b0; mem_ready = 1'b0;
    tick();
    checks++;
    if (m1_ack !== 1'b0) begin
      failures++;
      $display("FAIL write_ack_pulse: ack got %b expected 0", m1_ack);
    end
    tick();
  endtask

  task automatic test_burst;
    logic [9:0]  exp_seq;
    logic [31:0] exp_addr;
    exp_seq = 10'b10000_10000;
    m0_req = 1'b1; m0_addr = 32'h0000_0100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200;
    mem_ready = 1'b1; mem_rdata = 32'h55AA_55AA;
    for (int g = 0; g < 10; g++) begin
      exp_addr = exp_seq[g] ? 32'h0000_0200 : 32'h0000_0100;
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
        failures++;
        $display("FAIL burst_grant%0d: req=%b addr=%h expected 1 %h", g, mem_req, mem_addr, exp_addr);
      end
      tick();
      checks++;
      if ({m0_ack, m1_ack} !== (exp_seq[g] ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL burst_ack%0d: m0/m1 ack got %b expected %b", g, {m0_ack, m1_ack},
                 exp_seq[g] ? 2'b01 : 2'b10);
      end
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int   cnt;
    logic seen_done;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0040; mem_ready = 1'b0;
    tick();
    cnt = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      if (mem_req === 1'b1) begin
        cnt++;
        tick();
      end else begin
        seen_done = 1'b1;
      end
    end
    checks++;
    if (cnt != 15) begin
      failures++;
      $display("FAIL timeout_len: mem_req cycles got %0d expected 15", cnt);
    end
    checks++;
    if (m1_ack !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'h0) begin
      failures++;
      $display("FAIL timeout_ack: ack=%b err=%b rdata=%h expected 1 1 00000000", m1_ack, m1_err, m1_rdata);
    end
    m1_req = 1'b0;
    tick();
    checks++;
    if (m1_ack !== 1'b0 || m1_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse: ack=%b err=%b expected 0 0", m1_ack, m1_err);
    end
  endtask

  task automatic test_ready_at_timeout;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0044;
    mem_ready = 1'b0; mem_rdata = 32'hA5A5_0001;
    tick();
    repeat (14) tick();
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL edge_busy: mem_req got %b expected 1", mem_req);
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (m1_ack !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL edge_ready_wins: ack=%b err=%b rdata=%h expected 1 0 a5a50001",
               m1_ack, m1_err, m1_rdata);
    end
    m1_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy;
    logic [4:0]  exp_seq;
    logic [31:0] exp_addr;
    m0_req = 1'b1; m0_addr = 32'h0000_0100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200;
    mem_ready = 1'b1; mem_rdata = 32'h0000_7777;
    repeat (6) tick();
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0100) begin
      failures++;
      $display("FAIL rst_pre_busy: req=%b addr=%h expected 1 00000100", mem_req, mem_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_busy: req=%b m0_ack=%b m1_ack=%b expected 0 0 0", mem_req, m0_ack, m1_ack);
    end
    @(negedge clk);
    reset = 1'b1;
    // A cleared streak gives VGA four grants before the CPU slot again.
    exp_seq = 5'b10000;
    for (int g = 0; g < 5; g++) begin
      exp_addr = exp_seq[g] ? 32'h0000_0200 : 32'h0000_0100;
      tick();
      checks++;
      if (mem_addr !== exp_addr) begin
        failures++;
        $display("FAIL rst_streak%0d: addr got %h expected %h", g, mem_addr, exp_addr);
      end
      tick();
      tick();
    end
    m1_req = 1'b0;
    tick();
    tick();
    checks++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'h0000_7777) begin
      failures++;
      $display("FAIL rst_pre_done: ack=%b rdata=%h expected 1 00007777", m0_ack, m0_rdata);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (m0_ack !== 1'b0 || m0_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_async_done: ack=%b rdata=%h expected 0 00000000", m0_ack, m0_rdata);
    end
    m0_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      failures++;
      $display("FAIL rst_spurious: req=%b m0_ack=%b m1_ack=%b expected 0 0 0", mem_req, m0_ack, m1_ack);
    end
  endtask

  task automatic test_drop_in_busy;
    int acks;
    int reqs;
    m0_req = 1'b1; m0_addr = 32'h0000_0300; mem_ready = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0300 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL drop_grant: req=%b addr=%h we=%b expected 1 00000300 0", mem_req, mem_addr, mem_we);
    end
    m0_req = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL drop_still_busy: mem_req got %b expected 1", mem_req);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0F0F_0F0F;
    tick();
    checks++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'h0F0F_0F0F) begin
      failures++;
      $display("FAIL drop_ack: ack=%b rdata=%h expected 1 0f0f0f0f", m0_ack, m0_rdata);
    end
    mem_ready = 1'b0;
    acks = 0;
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m0_ack === 1'b1) acks++;
      if (mem_req === 1'b1) reqs++;
    end
    checks++;
    if (acks != 0 || reqs != 0) begin
      failures++;
      $display("FAIL drop_no_regrant: extra acks=%0d mem_req cycles=%0d expected 0 0", acks, reqs);
    end
    checks++;
    if (m0_rdata !== 32'h0F0F_0F0F) begin
      failures++;
      $display("FAIL drop_rdata_hold: rdata got %h expected 0f0f0f0f", m0_rdata);
    end
  endtask

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m0_addr = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_m1_read();
    test_m1_write();
    test_burst();
    test_timeout();
    test_ready_at_timeout();
    test_reset_busy();
    test_drop_in_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
